// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the IF/D requester handshakes, their results and the shared memory port.
// Latency: none, this is wiring only.
// Backpressure: none here; the arbiter's gnt pulses pace the requesters.
// Modports: slave  = the arbiter (samples requests and memory response, drives grants, results, memory port).
//           master = the surrounding core/memory (drives requests and memory response, observes the rest).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req_;
  logic [ADDR_W-1:0] if_addr_;
  logic              if_gnt_;
  logic              if_done_;
  logic [DATA_W-1:0] if_rdata_;
  // load/store requester
  logic              d_req_;
  logic              d_we_;
  logic [ADDR_W-1:0] d_addr_;
  logic [DATA_W-1:0] d_wdata_;
  logic              d_gnt_;
  logic              d_done_;
  logic [DATA_W-1:0] d_rdata_;
  // shared memory port and status
  logic              mem_en_;
  logic              mem_we_;
  logic [ADDR_W-1:0] mem_addr_;
  logic [DATA_W-1:0] mem_wdata_;
  logic [DATA_W-1:0] mem_rdata_;
  logic              mem_ack_;
  logic              sel_;
  logic              busy_;
  logic              timeout_err_;

  modport slave (
    input  if_req_, if_addr_,
    input  d_req_, d_we_, d_addr_, d_wdata_,
    input  mem_rdata_, mem_ack_,
    output if_gnt_, if_done_, if_rdata_,
    output d_gnt_, d_done_, d_rdata_,
    output mem_en_, mem_we_, mem_addr_, mem_wdata_,
    output sel_, busy_, timeout_err_
  );

  modport master (
    output if_req_, if_addr_,
    output d_req_, d_we_, d_addr_, d_wdata_,
    output mem_rdata_, mem_ack_,
    input  if_gnt_, if_done_, if_rdata_,
    input  d_gnt_, d_done_, d_rdata_,
    input  mem_en_, mem_we_, mem_addr_, mem_wdata_,
    input  sel_, busy_, timeout_err_
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch (IF) and load/store (D).
// Latency: gnt 1 cycle after a request seen in IDLE; done 1 cycle after mem_ack_, or MAX_WAIT cycles after gnt on abort.
// Backpressure: requesters hold a level request until their gnt pulse; one IDLE cycle separates consecutive accesses.
// Ports: clk_ (rising edge), rst_n_ (async active-low); every handshake/result/memory signal is on bus (slave modport).
//        sel_ steers the address/data mux in front of memory: 0 = IF, 1 = D. All outputs are registered.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15   // legal 1..255
) (
  input  logic              clk_,
  input  logic              rst_n_,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  localparam logic              OWN_IF     = 1'b0;
  localparam logic              OWN_D      = 1'b1;
  // The counter holds the number of ack-less cycles already spent; the abort
  // fires on the edge that would make it reach MAX_WAIT.
  localparam logic [7:0]        WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

  state_t            state_q;
  logic              last_owner_q;
  logic [7:0]        wait_cnt_q;
  logic              if_gnt_q, if_done_q;
  logic              d_gnt_q, d_done_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              sel_q, busy_q, timeout_err_q;

  logic gnt_any_d;   // some requester is asking
  logic gnt_own_d;   // who would win a grant this cycle
  logic at_limit_d;  // this grant-state cycle is the last one allowed without ack

  always_comb begin
    gnt_any_d  = bus.if_req_ | bus.d_req_;
    // Round-robin on a tie: the requester that did not own the port last time wins.
    gnt_own_d  = (bus.if_req_ & bus.d_req_) ? ~last_owner_q : bus.d_req_;
    at_limit_d = (wait_cnt_q == WAIT_LAST);
  end

  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_) begin
      state_q       <= IDLE;
      last_owner_q  <= OWN_D;   // so IF wins the first tie
      wait_cnt_q    <= '0;
      if_gnt_q      <= 1'b0;
      if_done_q     <= 1'b0;
      d_gnt_q       <= 1'b0;
      d_done_q      <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      sel_q         <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // gnt/done are single-cycle pulses
      if_gnt_q  <= 1'b0;
      d_gnt_q   <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          // mem_ack_ is deliberately not looked at here
          if (gnt_any_d) begin
            state_q      <= (gnt_own_d == OWN_D) ? GNT_D : GNT_IF;
            last_owner_q <= gnt_own_d;
            sel_q        <= gnt_own_d;
            wait_cnt_q   <= '0;
            mem_en_q     <= 1'b1;
            busy_q       <= 1'b1;
            if (gnt_own_d == OWN_D) begin
              d_gnt_q     <= 1'b1;
              mem_addr_q  <= bus.d_addr_;
              mem_wdata_q <= bus.d_wdata_;
              mem_we_q    <= bus.d_we_;
            end else begin
              if_gnt_q   <= 1'b1;
              mem_addr_q <= bus.if_addr_;
              mem_we_q   <= 1'b0;
            end
          end
        end

        GNT_IF, GNT_D: begin
          // An ack on the limit cycle still counts as a normal completion.
          if (bus.mem_ack_ || at_limit_d) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            if (!bus.mem_ack_) begin
              timeout_err_q <= 1'b1;
            end
            if (state_q == GNT_IF) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.mem_ack_ ? bus.mem_rdata_ : ABORT_DATA;
            end else begin
              d_done_q <= 1'b1;
              if (!bus.mem_ack_) begin
                d_rdata_q <= ABORT_DATA;
              end else if (!mem_we_q) begin
                d_rdata_q <= bus.mem_rdata_;   // stores leave the last load value alone
              end
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt_      = if_gnt_q;
  assign bus.if_done_     = if_done_q;
  assign bus.if_rdata_    = if_rdata_q;
  assign bus.d_gnt_       = d_gnt_q;
  assign bus.d_done_      = d_done_q;
  assign bus.d_rdata_     = d_rdata_q;
  assign bus.mem_en_      = mem_en_q;
  assign bus.mem_we_      = mem_we_q;
  assign bus.mem_addr_    = mem_addr_q;
  assign bus.mem_wdata_   = mem_wdata_q;
  assign bus.sel_         = sel_q;
  assign bus.busy_        = busy_q;
  assign bus.timeout_err_ = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: the memory responder acks ack_lat cycles after mem_en_ rises (ack_lat < 0 never acks).
// Backpressure: requesters hold their request until gnt, as the arbiter expects.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 15;

  logic clk_  = 1'b0;
  logic rst_n_ = 1'b1;
  always #5 clk_ = ~clk_;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk_  (clk_),
    .rst_n_(rst_n_),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ack_lat = -1;
  bit spur_en = 1'b0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hA5A5_0101;
  endfunction

  // Memory: single-cycle ack ack_lat cycles after mem_en_ rises; optional stray acks while idle.
  initial begin : responder
    bit en_seen;
    int cnt;
    en_seen = 1'b0;
    cnt = 0;
    bus.mem_ack_   = 1'b0;
    bus.mem_rdata_ = '0;
    forever begin
      @(posedge clk_);
      #1;
      bus.mem_ack_ = 1'b0;
      if (bus.mem_en_) begin
        if (!en_seen) begin
          en_seen = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
        if (cnt == ack_lat) begin
          bus.mem_ack_   = 1'b1;
          bus.mem_rdata_ = mem_fn(bus.mem_addr_);
        end
      end else begin
        en_seen = 1'b0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          bus.mem_ack_   = 1'b1;
          bus.mem_rdata_ = $urandom;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_   = 1'b0;
    bus.if_addr_  = '0;
    bus.d_req_    = 1'b0;
    bus.d_we_     = 1'b0;
    bus.d_addr_   = '0;
    bus.d_wdata_  = '0;
  endtask

  task automatic do_reset();
    rst_n_ = 1'b0;
    clear_inputs();
    repeat (2) tick();
    rst_n_ = 1'b1;
  endtask

  task automatic wait_gnt(input int limit, output int cyc);
    cyc = 0;
    forever begin
      tick();
      cyc++;
      if (bus.if_gnt_ || bus.d_gnt_) return;
      if (cyc >= limit) begin
        cyc = -1;
        return;
      end
    end
  endtask

  // Called in the grant cycle; counts edges to the done pulse, busy cycles, and whether the
  // latched address (and write data when chk_w) stayed put until done.
  task automatic wait_done(input int limit, input logic [31:0] ea, input logic [31:0] ew,
                           input bit chk_w, output int cyc, output int bcnt, output bit held);
    cyc  = 0;
    bcnt = bus.busy_ ? 1 : 0;
    held = 1'b1;
    forever begin
      if (bus.mem_addr_ !== ea || (chk_w && bus.mem_wdata_ !== ew)) held = 1'b0;
      tick();
      cyc++;
      if (bus.if_done_ || bus.d_done_) return;
      if (bus.busy_) bcnt++;
      if (cyc >= limit) begin
        cyc = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n_ = 1'b0;
    clear_inputs();
    #1;   // before any clock edge: reset must act asynchronously
    checks++;
    if ({bus.if_gnt_, bus.if_done_, bus.d_gnt_, bus.d_done_, bus.mem_en_, bus.mem_we_,
         bus.sel_, bus.busy_, bus.timeout_err_} !== 9'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 0", {bus.if_gnt_, bus.if_done_,
        bus.d_gnt_, bus.d_done_, bus.mem_en_, bus.mem_we_, bus.sel_, bus.busy_, bus.timeout_err_}); end
    checks++;
    if ({bus.if_rdata_, bus.d_rdata_, bus.mem_addr_, bus.mem_wdata_} !== 128'b0)
      begin errors++; $display("FAIL reset_data: got %h want 0",
        {bus.if_rdata_, bus.d_rdata_, bus.mem_addr_, bus.mem_wdata_}); end
    repeat (2) tick();
    rst_n_ = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.busy_ !== 1'b0 || bus.mem_en_ !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: busy %b en %b want 0 0", bus.busy_, bus.mem_en_); end
  endtask

  task automatic test_if_read();
    int cyc, bc;
    bit held;
    bus.if_req_  = 1'b1;
    bus.if_addr_ = 32'h100;
    ack_lat = 2;
    tick();
    checks++;
    if ({bus.if_gnt_, bus.d_gnt_} !== 2'b10)
      begin errors++; $display("FAIL if_gnt: got %b want 10", {bus.if_gnt_, bus.d_gnt_}); end
    checks++;
    if ({bus.sel_, bus.mem_we_, bus.mem_en_, bus.busy_} !== 4'b0011)
      begin errors++; $display("FAIL if_port: sel/we/en/busy got %b want 0011",
        {bus.sel_, bus.mem_we_, bus.mem_en_, bus.busy_}); end
    checks++;
    if (bus.mem_addr_ !== 32'h100)
      begin errors++; $display("FAIL if_addr: got %h want 00000100", bus.mem_addr_); end
    bus.if_req_ = 1'b0;
    wait_done(40, 32'h100, 32'h0, 1'b0, cyc, bc, held);
    checks++;
    if (cyc !== 3 || bc !== 3)
      begin errors++; $display("FAIL if_timing: done after %0d busy %0d want 3 3", cyc, bc); end
    checks++;
    if ({bus.if_done_, bus.d_done_} !== 2'b10 || bus.if_rdata_ !== 32'hA5A5_0001)
      begin errors++; $display("FAIL if_done: done %b rdata %h want 10 a5a50001",
        {bus.if_done_, bus.d_done_}, bus.if_rdata_); end
    tick();
    checks++;
    if (bus.if_done_ !== 1'b0 || bus.busy_ !== 1'b0)
      begin errors++; $display("FAIL if_pulse: done %b busy %b want 0 0", bus.if_done_, bus.busy_); end
  endtask

  task automatic test_d_store();
    int cyc, bc;
    bit held;
    bus.d_req_   = 1'b1;
    bus.d_we_    = 1'b1;
    bus.d_addr_  = 32'h200;
    bus.d_wdata_ = 32'h1234_5678;
    ack_lat = 3;
    tick();
    checks++;
    if ({bus.d_gnt_, bus.sel_, bus.mem_we_, bus.mem_en_} !== 4'b1111 || bus.if_gnt_ !== 1'b0)
      begin errors++; $display("FAIL d_gnt: gnt/sel/we/en got %b want 1111",
        {bus.d_gnt_, bus.sel_, bus.mem_we_, bus.mem_en_}); end
    // change everything the cycle after the grant; the port must not follow
    bus.d_req_   = 1'b0;
    bus.d_we_    = 1'b0;
    bus.d_addr_  = 32'hFFF0;
    bus.d_wdata_ = 32'hDEAD_0000;
    wait_done(40, 32'h200, 32'h1234_5678, 1'b1, cyc, bc, held);
    checks++;
    if (!held || cyc !== 4)
      begin errors++; $display("FAIL d_hold: held %b done after %0d want 1 4", held, cyc); end
    checks++;
    if (bus.d_done_ !== 1'b1 || bus.d_rdata_ !== 32'h0)
      begin errors++; $display("FAIL d_store_done: done %b rdata %h want 1 00000000", bus.d_done_, bus.d_rdata_); end
    tick();
  endtask

  task automatic test_contention();
    int cyc, bc;
    bit held;
    do_reset();
    bus.if_req_  = 1'b1;
    bus.if_addr_ = 32'h40;
    bus.d_req_   = 1'b1;
    bus.d_we_    = 1'b0;
    bus.d_addr_  = 32'h80;
    ack_lat = 1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(5, cyc);
      checks++;
      if (cyc !== 1 || {bus.if_gnt_, bus.d_gnt_} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL rr_grant%0d: gap %0d gnt %b want 1 %b", k, cyc,
          {bus.if_gnt_, bus.d_gnt_}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      wait_done(20, (k % 2 == 0) ? 32'h40 : 32'h80, 32'h0, 1'b0, cyc, bc, held);
      checks++;
      if (cyc !== 2 || !held)
        begin errors++; $display("FAIL rr_done%0d: after %0d held %b want 2 1", k, cyc, held); end
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int cyc, bc;
    bit held;
    do_reset();
    bus.if_req_  = 1'b1;
    bus.if_addr_ = 32'h300;
    ack_lat = -1;
    tick();
    bus.if_req_ = 1'b0;
    wait_done(40, 32'h300, 32'h0, 1'b0, cyc, bc, held);
    checks++;
    if (cyc !== MW || bus.if_done_ !== 1'b1 || bus.if_rdata_ !== 32'hDEAD_BEEF || bus.timeout_err_ !== 1'b1)
      begin errors++; $display("FAIL timeout: after %0d done %b rdata %h err %b want %0d 1 deadbeef 1",
        cyc, bus.if_done_, bus.if_rdata_, bus.timeout_err_, MW); end
    // a later normal load must complete but leave the error flag set
    bus.d_req_  = 1'b1;
    bus.d_we_   = 1'b0;
    bus.d_addr_ = 32'h400;
    ack_lat = 1;
    tick();
    bus.d_req_ = 1'b0;
    wait_done(40, 32'h400, 32'h0, 1'b0, cyc, bc, held);
    checks++;
    if (cyc !== 2 || bus.d_rdata_ !== mem_fn(32'h400) || bus.timeout_err_ !== 1'b1)
      begin errors++; $display("FAIL sticky_err: after %0d rdata %h err %b want 2 %h 1",
        cyc, bus.d_rdata_, bus.timeout_err_, mem_fn(32'h400)); end
    tick();
  endtask

  task automatic test_ack_limit();
    int cyc, bc;
    bit held;
    do_reset();
    bus.if_req_  = 1'b1;
    bus.if_addr_ = 32'h500;
    ack_lat = MW - 1;
    tick();
    bus.if_req_ = 1'b0;
    wait_done(40, 32'h500, 32'h0, 1'b0, cyc, bc, held);
    checks++;
    if (cyc !== MW || bus.if_rdata_ !== mem_fn(32'h500) || bus.timeout_err_ !== 1'b0)
      begin errors++; $display("FAIL ack_at_limit: after %0d rdata %h err %b want %0d %h 0",
        cyc, bus.if_rdata_, bus.timeout_err_, MW, mem_fn(32'h500)); end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    bit held;
    bit seen_done;
    do_reset();
    bus.d_req_  = 1'b1;
    bus.d_we_   = 1'b0;
    bus.d_addr_ = 32'h600;
    ack_lat = -1;
    tick();
    checks++;
    if (bus.d_gnt_ !== 1'b1)
      begin errors++; $display("FAIL mid_gnt: d_gnt %b want 1", bus.d_gnt_); end
    bus.d_req_ = 1'b0;
    seen_done = 1'b0;
    repeat (3) begin
      tick();
      if (bus.d_done_) seen_done = 1'b1;
    end
    #2;
    rst_n_ = 1'b0;
    #1;
    checks++;
    if ({bus.d_gnt_, bus.d_done_, bus.mem_en_, bus.mem_we_, bus.sel_, bus.busy_, bus.timeout_err_} !== 7'b0 ||
        bus.mem_addr_ !== 32'h0 || bus.d_rdata_ !== 32'h0)
      begin errors++; $display("FAIL mid_reset: ctrl %b addr %h rdata %h want 0",
        {bus.d_gnt_, bus.d_done_, bus.mem_en_, bus.mem_we_, bus.sel_, bus.busy_, bus.timeout_err_},
        bus.mem_addr_, bus.d_rdata_); end
    repeat (3) begin
      tick();
      if (bus.d_done_) seen_done = 1'b1;
    end
    rst_n_ = 1'b1;
    tick();
    if (bus.d_done_) seen_done = 1'b1;
    checks++;
    if (seen_done)
      begin errors++; $display("FAIL mid_no_done: d_done seen 1 want 0"); end
    bus.if_req_  = 1'b1;
    bus.if_addr_ = 32'h700;
    bus.d_req_   = 1'b1;
    bus.d_addr_  = 32'h800;
    ack_lat = 0;
    tick();
    checks++;
    if ({bus.if_gnt_, bus.d_gnt_} !== 2'b10)
      begin errors++; $display("FAIL post_reset_tie: gnt %b want 10", {bus.if_gnt_, bus.d_gnt_}); end
    // D withdraws before it is ever granted: it must not get a transaction
    clear_inputs();
    wait_done(20, 32'h700, 32'h0, 1'b0, cyc, bc, held);
    checks++;
    if (cyc !== 1 || bus.if_rdata_ !== mem_fn(32'h700))
      begin errors++; $display("FAIL min_access: after %0d rdata %h want 1 %h", cyc, bus.if_rdata_, mem_fn(32'h700)); end
    seen_done = 1'b0;
    repeat (4) begin
      tick();
      if (bus.d_gnt_ || bus.busy_) seen_done = 1'b1;
    end
    checks++;
    if (seen_done)
      begin errors++; $display("FAIL dropped_req: port became busy, want idle"); end
  endtask

  task automatic test_random();
    bit if_pend, d_pend, d_w, own, last_m, err_m, aborted, held;
    logic [31:0] if_a, d_a, d_wd, if_rd_m, d_rd_m, exp_a;
    int lat, cyc, bc, exp_cyc;
    do_reset();
    spur_en = 1'b1;
    if_pend = 1'b0; d_pend = 1'b0; d_w = 1'b0;
    if_a = '0; d_a = '0; d_wd = '0;
    last_m = 1'b1; err_m = 1'b0; if_rd_m = '0; d_rd_m = '0;
    for (int n = 0; n < 60; n++) begin
      if (!if_pend && !d_pend && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
        checks++;
        if (bus.busy_ !== 1'b0)
          begin errors++; $display("FAIL rnd_idle%0d: busy %b want 0", n, bus.busy_); end
      end
      if (!if_pend && $urandom_range(0, 1) == 1) begin if_pend = 1'b1; if_a = $urandom; end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1; d_a = $urandom; d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
      end
      if (!if_pend && !d_pend) begin if_pend = 1'b1; if_a = $urandom; end
      bus.if_req_ = if_pend; bus.if_addr_ = if_a;
      bus.d_req_ = d_pend; bus.d_addr_ = d_a; bus.d_we_ = d_w; bus.d_wdata_ = d_wd;
      own = (if_pend && d_pend) ? !last_m : d_pend;
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 4));
      ack_lat = lat;
      exp_a = own ? d_a : if_a;
      tick();
      checks++;
      if ({bus.if_gnt_, bus.d_gnt_} !== (own ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL rnd_gnt%0d: got %b want %b", n, {bus.if_gnt_, bus.d_gnt_}, own ? 2'b01 : 2'b10); end
      checks++;
      if ({bus.sel_, bus.mem_we_, bus.mem_addr_} !== {own, own & d_w, exp_a})
        begin errors++; $display("FAIL rnd_port%0d: sel/we/addr got %b %b %h want %b %b %h", n,
          bus.sel_, bus.mem_we_, bus.mem_addr_, own, own & d_w, exp_a); end
      last_m = own;
      if (own) begin
        d_pend = 1'b0; bus.d_req_ = 1'b0;
        bus.d_addr_ = $urandom; bus.d_wdata_ = $urandom; bus.d_we_ = 1'($urandom_range(0, 1));
      end else begin
        if_pend = 1'b0; bus.if_req_ = 1'b0; bus.if_addr_ = $urandom;
      end
      wait_done(40, exp_a, d_wd, own & d_w, cyc, bc, held);
      aborted = (lat > MW - 1);
      exp_cyc = aborted ? MW : lat + 1;
      err_m   = err_m | aborted;
      if (!own) if_rd_m = aborted ? 32'hDEAD_BEEF : mem_fn(if_a);
      else if (aborted) d_rd_m = 32'hDEAD_BEEF;
      else if (!d_w) d_rd_m = mem_fn(d_a);
      checks++;
      if (cyc !== exp_cyc || {bus.if_done_, bus.d_done_} !== (own ? 2'b01 : 2'b10) || !held)
        begin errors++; $display("FAIL rnd_done%0d: after %0d done %b held %b want %0d %b 1", n,
          cyc, {bus.if_done_, bus.d_done_}, held, exp_cyc, own ? 2'b01 : 2'b10); end
      checks++;
      if (bus.if_rdata_ !== if_rd_m || bus.d_rdata_ !== d_rd_m || bus.timeout_err_ !== err_m)
        begin errors++; $display("FAIL rnd_data%0d: if %h d %h err %b want %h %h %b", n,
          bus.if_rdata_, bus.d_rdata_, bus.timeout_err_, if_rd_m, d_rd_m, err_m); end
    end
    spur_en = 1'b0;
    clear_inputs();
    repeat (3) tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_if_read();
    test_d_store();
    test_contention();
    test_timeout();
    test_ack_limit();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
